lcd_bus_sched: RTL and testbench

//   Owns the HD44780-style 8-bit LCD bus. After power-up it runs a fixed init sequence,

---
 rtl/lcd_bus_sched.sv | 193 +++++++++++++++++++
 tb/tb_lcd_bus_sched.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_sched.sv
// HD44780-style 8-bit LCD bus owner: power-up delay, fixed init list, then
// round-robin arbitration between command and character writers with E-strobe timing.
module lcd_bus_sched #(
   parameter int T_PWRUP = 750000,
   parameter int T_SETUP = 2,
   parameter int T_EPW   = 25,
   parameter int T_HOLD  = 2,
   parameter int T_EXEC  = 2000,
   parameter int T_LONG  = 80000,
   parameter int CW      = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   input  logic [7:0] cmd_data,
   output logic       cmd_ready,
   input  logic       chr_valid,
   input  logic [7:0] chr_data,
   output logic       chr_ready,
   output logic       init_done,
   output logic       busy,
   output logic [7:0] lcd_data,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw
);

   localparam logic [2:0] S_PWRUP = 3'd0;
   localparam logic [2:0] S_IDLE  = 3'd1;
   localparam logic [2:0] S_SETUP = 3'd2;
   localparam logic [2:0] S_PULSE = 3'd3;
   localparam logic [2:0] S_HOLD  = 3'd4;
   localparam logic [2:0] S_EXEC  = 3'd5;

   localparam logic [CW-1:0] PWRUP_LAST = CW'(T_PWRUP - 1);
   localparam logic [CW-1:0] SETUP_LD   = CW'(T_SETUP - 1);
   localparam logic [CW-1:0] EPW_LD     = CW'(T_EPW - 1);
   localparam logic [CW-1:0] HOLD_LD    = CW'(T_HOLD - 1);
   localparam logic [CW-1:0] EXEC_LD    = CW'(T_EXEC - 1);
   localparam logic [CW-1:0] LONG_LD    = CW'(T_LONG - 1);

   logic [2:0]    state_r;
   logic [CW-1:0] timer_r;
   logic [1:0]    init_idx_r;
   logic          last_cmd_r;
   logic [7:0]    lcd_data_r;
   logic          lcd_rs_r;
   logic          lcd_e_r;
   logic          init_done_r;
   logic          busy_r;
   logic          cmd_ready_s;
   logic          chr_ready_s;
   logic          timer_zero_s;
   logic          long_wait_s;

   function automatic logic [7:0] init_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    init_byte = 8'h38;
         2'd1:    init_byte = 8'h0C;
         2'd2:    init_byte = 8'h01;
         2'd3:    init_byte = 8'h06;
         default: init_byte = 8'h00;
      endcase
   endfunction

   assign timer_zero_s = (timer_r == {CW{1'b0}});
   // clear display / return home need the long execution wait
   assign long_wait_s  = !lcd_rs_r && (lcd_data_r[7:2] == 6'd0) && (lcd_data_r != 8'h00);

   // Round-robin grant: on a tie the requester not granted last time wins.
   always_comb begin
      cmd_ready_s = 1'b0;
      chr_ready_s = 1'b0;
      if ((state_r == S_IDLE) && init_done_r) begin
         if (cmd_valid && chr_valid) begin
            cmd_ready_s = !last_cmd_r;
            chr_ready_s = last_cmd_r;
         end else begin
            cmd_ready_s = cmd_valid;
            chr_ready_s = chr_valid;
         end
      end else begin
         cmd_ready_s = 1'b0;
         chr_ready_s = 1'b0;
      end
   end

   // Main sequencer: power-up wait, init list, and per-write setup/pulse/hold/exec.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_PWRUP;
         timer_r     <= {CW{1'b0}};
         init_idx_r  <= 2'd0;
         last_cmd_r  <= 1'b0;
         lcd_data_r  <= 8'h00;
         lcd_rs_r    <= 1'b0;
         lcd_e_r     <= 1'b0;
         init_done_r <= 1'b0;
         busy_r      <= 1'b1;
      end else begin
         case (state_r)
            // power-up counts upward from the zero reset value
            S_PWRUP: begin
               if (timer_r == PWRUP_LAST) begin
                  state_r    <= S_SETUP;
                  timer_r    <= SETUP_LD;
                  lcd_data_r <= init_byte(init_idx_r);
                  lcd_rs_r   <= 1'b0;
               end else begin
                  timer_r <= timer_r + CW'(1);
               end
            end
            S_IDLE: begin
               if (cmd_ready_s) begin
                  state_r    <= S_SETUP;
                  timer_r    <= SETUP_LD;
                  lcd_data_r <= cmd_data;
                  lcd_rs_r   <= 1'b0;
                  last_cmd_r <= 1'b1;
                  busy_r     <= 1'b1;
               end else if (chr_ready_s) begin
                  state_r    <= S_SETUP;
                  timer_r    <= SETUP_LD;
                  lcd_data_r <= chr_data;
                  lcd_rs_r   <= 1'b1;
                  last_cmd_r <= 1'b0;
                  busy_r     <= 1'b1;
               end else begin
                  timer_r <= {CW{1'b0}};
               end
            end
            S_SETUP: begin
               if (timer_zero_s) begin
                  state_r <= S_PULSE;
                  timer_r <= EPW_LD;
                  lcd_e_r <= 1'b1;
               end else begin
                  timer_r <= timer_r - CW'(1);
               end
            end
            S_PULSE: begin
               if (timer_zero_s) begin
                  state_r <= S_HOLD;
                  timer_r <= HOLD_LD;
                  lcd_e_r <= 1'b0;
               end else begin
                  timer_r <= timer_r - CW'(1);
               end
            end
            S_HOLD: begin
               if (timer_zero_s) begin
                  state_r <= S_EXEC;
                  timer_r <= long_wait_s ? LONG_LD : EXEC_LD;
               end else begin
                  timer_r <= timer_r - CW'(1);
               end
            end
            S_EXEC: begin
               if (!timer_zero_s) begin
                  timer_r <= timer_r - CW'(1);
               end else if (init_done_r || (init_idx_r == 2'd3)) begin
                  state_r     <= S_IDLE;
                  timer_r     <= {CW{1'b0}};
                  init_done_r <= 1'b1;
                  busy_r      <= 1'b0;
               end else begin
                  state_r    <= S_SETUP;
                  timer_r    <= SETUP_LD;
                  init_idx_r <= init_idx_r + 2'd1;
                  lcd_data_r <= init_byte(init_idx_r + 2'd1);
                  lcd_rs_r   <= 1'b0;
               end
            end
            default: begin
               state_r <= S_PWRUP;
               timer_r <= {CW{1'b0}};
               lcd_e_r <= 1'b0;
               busy_r  <= 1'b1;
            end
         endcase
      end
   end

   assign cmd_ready = cmd_ready_s;
   assign chr_ready = chr_ready_s;
   assign init_done = init_done_r;
   assign busy      = busy_r;
   assign lcd_data  = lcd_data_r;
   assign lcd_e     = lcd_e_r;
   assign lcd_rs    = lcd_rs_r;
   assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_bus_sched.sv
// Directed bench for lcd_bus_sched with short timing parameters:
// init sequence, character/command timing, round-robin ties and mid-write reset.
module tb_lcd_bus_sched;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [7:0] cmd_data = 8'h00;
   logic       cmd_ready;
   logic       chr_valid = 1'b0;
   logic [7:0] chr_data = 8'h00;
   logic       chr_ready;
   logic       init_done;
   logic       busy;
   logic [7:0] lcd_data;
   logic       lcd_e;
   logic       lcd_rs;
   logic       lcd_rw;

   int checks = 0;
   int errors = 0;

   lcd_bus_sched #(
      .T_PWRUP(10), .T_SETUP(1), .T_EPW(3), .T_HOLD(1),
      .T_EXEC(5), .T_LONG(20), .CW(20)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
      .chr_valid(chr_valid), .chr_data(chr_data), .chr_ready(chr_ready),
      .init_done(init_done), .busy(busy),
      .lcd_data(lcd_data), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Steps until busy drops; returns cycles from the accept edge and E-high cycles.
   task automatic measure(output int n, output int ehi);
      n = 0;
      ehi = 0;
      for (int k = 1; k <= 100; k++) begin
         step();
         if (lcd_e) ehi++;
         if (!busy) begin
            n = k;
            break;
         end
      end
   endtask

   // From reset release: records the four init pulses and the init_done cycle.
   task automatic run_init(input string pfx);
      int         rises, ehi, done_n;
      bit         rdy_seen;
      logic       prev_e;
      int         redge [4];
      logic [7:0] rdata [4];
      logic       rrs   [4];
      logic [7:0] exp_d [4];
      int         exp_edge [4];
      exp_d    = '{8'h38, 8'h0C, 8'h01, 8'h06};
      exp_edge = '{11, 21, 31, 56};
      rises = 0; ehi = 0; done_n = 0; rdy_seen = 1'b0; prev_e = 1'b0;
      for (int n = 1; n <= 200; n++) begin
         step();
         if (lcd_e && !prev_e) begin
            if (rises < 4) begin
               redge[rises] = n;
               rdata[rises] = lcd_data;
               rrs[rises]   = lcd_rs;
            end
            rises++;
         end
         if (lcd_e) ehi++;
         prev_e = lcd_e;
         if (init_done) begin
            done_n = n;
            break;
         end
         if (cmd_ready || chr_ready) rdy_seen = 1'b1;
      end
      check({pfx, "_pulses"}, rises, 4);
      check({pfx, "_e_high_total"}, ehi, 12);
      check({pfx, "_done_cycle"}, done_n, 65);
      check({pfx, "_no_ready_during_init"}, rdy_seen, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s_data%0d", pfx, i), rdata[i], exp_d[i]);
         check($sformatf("%s_rs%0d", pfx, i), rrs[i], 1'b0);
         check($sformatf("%s_edge%0d", pfx, i), redge[i], exp_edge[i]);
      end
   endtask

   initial begin
      int n, ehi;
      bit exp_cmd;

      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_lcd_e", lcd_e, 1'b0);
      check("rst_lcd_rs", lcd_rs, 1'b0);
      check("rst_lcd_rw", lcd_rw, 1'b0);
      check("rst_lcd_data", lcd_data, 8'h00);
      check("rst_init_done", init_done, 1'b0);
      check("rst_busy", busy, 1'b1);
      check("rst_cmd_ready", cmd_ready, 1'b0);
      check("rst_chr_ready", chr_ready, 1'b0);

      @(negedge clk) rst_n = 1'b1;
      run_init("init1");
      check("idle_busy", busy, 1'b0);

      // Single character write
      chr_data = 8'h41; chr_valid = 1'b1;
      #1;
      check("chr_ready_idle", chr_ready, 1'b1);
      check("cmd_ready_idle", cmd_ready, 1'b0);
      step();
      chr_data = 8'h99; chr_valid = 1'b0;
      check("chr_rs", lcd_rs, 1'b1);
      check("chr_data", lcd_data, 8'h41);
      check("chr_busy", busy, 1'b1);
      measure(n, ehi);
      check("chr_cycles", n, 10);
      check("chr_e_high", ehi, 3);
      check("chr_data_held", lcd_data, 8'h41);

      // Clear display then cursor shift: long then normal wait
      cmd_data = 8'h01; cmd_valid = 1'b1;
      #1;
      check("cmd01_ready", cmd_ready, 1'b1);
      step();
      cmd_data = 8'h14;
      check("cmd01_rs", lcd_rs, 1'b0);
      check("cmd01_data", lcd_data, 8'h01);
      measure(n, ehi);
      check("cmd01_cycles", n, 25);
      check("cmd01_e_high", ehi, 3);
      check("cmd14_ready", cmd_ready, 1'b1);
      step();
      cmd_valid = 1'b0;
      check("cmd14_data", lcd_data, 8'h14);
      measure(n, ehi);
      check("cmd14_cycles", n, 10);

      // Both valid and held: alternation, last grant was cmd so chr first
      cmd_data = 8'h80; chr_data = 8'h5A; cmd_valid = 1'b1; chr_valid = 1'b1;
      #1;
      exp_cmd = 1'b0;
      for (int g = 0; g < 4; g++) begin
         check($sformatf("rr%0d_cmd_ready", g), cmd_ready, exp_cmd);
         check($sformatf("rr%0d_chr_ready", g), chr_ready, !exp_cmd);
         step();
         check($sformatf("rr%0d_rs", g), lcd_rs, !exp_cmd);
         check($sformatf("rr%0d_data", g), lcd_data, exp_cmd ? 8'h80 : 8'h5A);
         check($sformatf("rr%0d_ready_busy", g), cmd_ready | chr_ready, 1'b0);
         measure(n, ehi);
         check($sformatf("rr%0d_cycles", g), n, 10);
         exp_cmd = !exp_cmd;
      end
      chr_valid = 1'b0;

      // Reset during the E pulse
      cmd_data = 8'h0F;
      #1;
      check("mid_cmd_ready", cmd_ready, 1'b1);
      step();
      cmd_valid = 1'b0;
      step();
      check("mid_e_high", lcd_e, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_e", lcd_e, 1'b0);
      check("mid_rst_busy", busy, 1'b1);
      check("mid_rst_init_done", init_done, 1'b0);
      check("mid_rst_data", lcd_data, 8'h00);

      // Requests pending across re-init; tie must go to cmd first
      cmd_data = 8'h0E; chr_data = 8'h55; cmd_valid = 1'b1; chr_valid = 1'b1;
      @(negedge clk) rst_n = 1'b1;
      run_init("init2");
      check("post_init_cmd_ready", cmd_ready, 1'b1);
      check("post_init_chr_ready", chr_ready, 1'b0);
      step();
      check("post_init_cmd_data", lcd_data, 8'h0E);
      check("post_init_cmd_rs", lcd_rs, 1'b0);
      measure(n, ehi);
      check("post_init_cmd_cycles", n, 10);
      check("post_init_chr_ready2", chr_ready, 1'b1);
      step();
      cmd_valid = 1'b0; chr_valid = 1'b0;
      check("post_init_chr_data", lcd_data, 8'h55);
      check("post_init_chr_rs", lcd_rs, 1'b1);
      measure(n, ehi);
      check("post_init_chr_cycles", n, 10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
